// File: rtl/class_merge_if.sv
// class_merge_if
//   Bundles the FIFO read side, downstream side and status outputs of
//   class_merge so the merger and its environment share one connection.
//   Ports (as seen by the merger, modport slave):
//     fifo0_data/fifo1_data  in   per-class FIFO read data (valid the cycle after a pop)
//     fifo0_empty/fifo1_empty in  per-class FIFO empty flags
//     pause                  in   downstream backpressure
//     pop0/pop1              out  per-class FIFO read strobes
//     data_out/valid_out     out  merged, registered word stream
//     cnt0/cnt1              out  per-class delivered-word counters (wrap)
//     class_err              out  sticky class-bit mismatch flag
//   modport master is the environment view (FIFOs + downstream).
interface class_merge_if #(
  parameter int DATA_SIZE = 10,
  parameter int CNT_W     = 8
);
  logic [DATA_SIZE-1:0] fifo0_data;
  logic                 fifo0_empty;
  logic [DATA_SIZE-1:0] fifo1_data;
  logic                 fifo1_empty;
  logic                 pause;
  logic                 pop0;
  logic                 pop1;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  logic [CNT_W-1:0]     cnt0;
  logic [CNT_W-1:0]     cnt1;
  logic                 class_err;

  modport slave (
    input  fifo0_data, fifo0_empty, fifo1_data, fifo1_empty, pause,
    output pop0, pop1, data_out, valid_out, cnt0, cnt1, class_err
  );

  modport master (
    output fifo0_data, fifo0_empty, fifo1_data, fifo1_empty, pause,
    input  pop0, pop1, data_out, valid_out, cnt0, cnt1, class_err
  );
endinterface

// File: rtl/class_merge.sv
// class_merge
//   Drains the class-0 and class-1 FIFOs and merges them into one stream
//   using weighted round-robin (up to W0 / W1 consecutive pops per class
//   while the other class waits), honouring downstream pause.
//   Ports:
//     clk    in  clock, posedge
//     reset  in  asynchronous active-low reset
//     bus    class_merge_if.slave (FIFO read side, merged output, status)
//
//   state  | meaning
//   IDLE   | nothing to serve or paused; picks the next class, no pop
//   SERVE0 | popping class 0 while it is non-empty and burst < W0
//   SERVE1 | popping class 1 while it is non-empty and burst < W1
module class_merge #(
  parameter int DATA_SIZE = 10,
  parameter int W0        = 2,
  parameter int W1        = 2,
  parameter int CNT_W     = 8
) (
  input  logic          clk,
  input  logic          reset,
  class_merge_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SERVE0 = 2'd1;
  localparam logic [1:0] SERVE1 = 2'd2;

  localparam logic [3:0] W0_L = 4'(W0);
  localparam logic [3:0] W1_L = 4'(W1);

  logic [1:0]           state, state_nxt;
  logic [3:0]           burst, burst_nxt;
  logic [3:0]           burst_inc;
  logic                 last_served, last_nxt;
  logic                 pop0, pop1;

  // pop stage: word arrives on fifok_data one cycle after the pop
  logic                 p_valid;
  logic                 p_cls;
  logic [DATA_SIZE-1:0] word;

  logic [DATA_SIZE-1:0] data_out_r;
  logic                 valid_out_r;
  logic [CNT_W-1:0]     cnt0_r, cnt1_r;
  logic                 class_err_r;

  // burst never exceeds W-1 before the increment, so 4 bits cannot overflow
  assign burst_inc = burst + 4'd1;

  always_comb begin
    state_nxt = state;
    burst_nxt = burst;
    last_nxt  = last_served;
    pop0      = 1'b0;
    pop1      = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.pause) begin
          if (!bus.fifo0_empty && !bus.fifo1_empty)
            state_nxt = last_served ? SERVE0 : SERVE1;
          else if (!bus.fifo0_empty)
            state_nxt = SERVE0;
          else if (!bus.fifo1_empty)
            state_nxt = SERVE1;
        end
      end
      SERVE0: begin
        if (!bus.pause) begin
          if (!bus.fifo0_empty) begin
            pop0 = 1'b1;
            if (burst_inc == W0_L) begin
              burst_nxt = 4'd0;
              if (!bus.fifo1_empty) begin
                state_nxt = SERVE1;
                last_nxt  = 1'b0;
              end
            end else begin
              burst_nxt = burst_inc;
            end
          end else begin
            last_nxt  = 1'b0;
            burst_nxt = 4'd0;
            state_nxt = bus.fifo1_empty ? IDLE : SERVE1;
          end
        end
      end
      SERVE1: begin
        if (!bus.pause) begin
          if (!bus.fifo1_empty) begin
            pop1 = 1'b1;
            if (burst_inc == W1_L) begin
              burst_nxt = 4'd0;
              if (!bus.fifo0_empty) begin
                state_nxt = SERVE0;
                last_nxt  = 1'b1;
              end
            end else begin
              burst_nxt = burst_inc;
            end
          end else begin
            last_nxt  = 1'b1;
            burst_nxt = 4'd0;
            state_nxt = bus.fifo0_empty ? IDLE : SERVE0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        burst_nxt = 4'd0;
      end
    endcase
  end

  assign word = p_cls ? bus.fifo1_data : bus.fifo0_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      burst       <= 4'd0;
      last_served <= 1'b1;
      p_valid     <= 1'b0;
      p_cls       <= 1'b0;
      data_out_r  <= '0;
      valid_out_r <= 1'b0;
      cnt0_r      <= '0;
      cnt1_r      <= '0;
      class_err_r <= 1'b0;
    end else begin
      state       <= state_nxt;
      burst       <= burst_nxt;
      last_served <= last_nxt;
      // output pipeline runs regardless of pause
      p_valid     <= pop0 | pop1;
      p_cls       <= pop1;
      valid_out_r <= p_valid;
      if (p_valid) begin
        data_out_r <= word;
        if (p_cls) cnt1_r <= cnt1_r + CNT_W'(1);
        else       cnt0_r <= cnt0_r + CNT_W'(1);
        // mismatching words are still forwarded and counted by source FIFO
        if (word[DATA_SIZE-1] != p_cls) class_err_r <= 1'b1;
      end
    end
  end

  assign bus.pop0      = pop0;
  assign bus.pop1      = pop1;
  assign bus.data_out  = data_out_r;
  assign bus.valid_out = valid_out_r;
  assign bus.cnt0      = cnt0_r;
  assign bus.cnt1      = cnt1_r;
  assign bus.class_err = class_err_r;

endmodule

// File: tb/tb_class_merge.sv
module tb_class_merge;

  logic clk;
  logic reset;

  class_merge_if #(.DATA_SIZE(10), .CNT_W(8)) bus ();

  class_merge #(.DATA_SIZE(10), .W0(2), .W1(2), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [9:0] q0[$];
  logic [9:0] q1[$];

  // monitor state
  int         cyc = 0;
  logic [9:0] log_q[$];
  int         vcyc_q[$];
  int         pop0_cyc_q[$];
  int         pop_total = 0;
  int         both_cnt = 0;
  int         pause_pops = 0;
  int         pause_valids = 0;

  // FIFO model: pop seen in cycle N -> data and empty updated early in N+1
  always begin
    bit t0, t1;
    bus.fifo0_empty = (q0.size() == 0);
    bus.fifo1_empty = (q1.size() == 0);
    @(negedge clk);
    t0 = bus.pop0 && (q0.size() > 0);
    t1 = bus.pop1 && (q1.size() > 0);
    @(posedge clk);
    #1;
    if (t0) bus.fifo0_data = q0.pop_front();
    if (t1) bus.fifo1_data = q1.pop_front();
    #1;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.valid_out) begin
      log_q.push_back(bus.data_out);
      vcyc_q.push_back(cyc);
    end
    if (bus.pop0) pop0_cyc_q.push_back(cyc);
    if (bus.pop0 || bus.pop1) pop_total++;
    if (bus.pop0 && bus.pop1) both_cnt++;
    if (bus.pause) begin
      if (bus.pop0 || bus.pop1) pause_pops++;
      if (bus.valid_out) pause_valids++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_words(input int target, input int budget);
    for (int i = 0; i < budget && log_q.size() < target; i++) settle();
  endtask

  task automatic wait_pop0(input int budget);
    for (int i = 0; i < budget && !bus.pop0; i++) settle();
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  logic [9:0] exp3 [12] = '{10'h011, 10'h012, 10'h201, 10'h202,
                            10'h013, 10'h014, 10'h203, 10'h204,
                            10'h015, 10'h016, 10'h205, 10'h206};

  initial begin
    int base, pbase, ptot;
    reset     = 1'b0;
    bus.pause = 1'b0;

    // reset state
    #2;
    chk("rst_pop0", bus.pop0, 0);
    chk("rst_pop1", bus.pop1, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_cnt0", bus.cnt0, 0);
    chk("rst_cnt1", bus.cnt1, 0);
    chk("rst_err", bus.class_err, 0);
    tick();
    tick();
    reset = 1'b1;

    // idle with both FIFOs empty
    ptot = pop_total;
    base = log_q.size();
    for (int i = 0; i < 20; i++) settle();
    chk("idle_pops", pop_total - ptot, 0);
    chk("idle_valids", log_q.size() - base, 0);
    chk("idle_cnt0", bus.cnt0, 0);
    chk("idle_cnt1", bus.cnt1, 0);

    // class 0 only, five words
    tick();
    base  = log_q.size();
    pbase = pop0_cyc_q.size();
    for (int i = 1; i <= 5; i++) q0.push_back(10'(i));
    wait_words(base + 5, 60);
    chk("c0_count", log_q.size() - base, 5);
    for (int i = 0; i < 5; i++) chk("c0_data", log_q[base+i], 32'(i + 1));
    chk("c0_latency", vcyc_q[base] - pop0_cyc_q[pbase], 2);
    chk("c0_span", vcyc_q[base+4] - vcyc_q[base], 4);
    chk("c0_pop_span", pop0_cyc_q[pbase+4] - pop0_cyc_q[pbase], 4);
    for (int i = 0; i < 3; i++) settle();
    chk("c0_hold_data", bus.data_out, 10'h005);
    chk("c0_hold_valid", bus.valid_out, 0);
    chk("c0_cnt0", bus.cnt0, 5);
    chk("c0_cnt1", bus.cnt1, 0);

    // both classes, weighted round-robin, class 0 first after reset
    do_reset();
    settle();
    chk("rr_rst_cnt0", bus.cnt0, 0);
    tick();
    base = log_q.size();
    for (int i = 1; i <= 6; i++) begin
      q0.push_back(10'h010 + 10'(i));
      q1.push_back(10'h200 + 10'(i));
    end
    wait_words(base + 12, 100);
    chk("rr_count", log_q.size() - base, 12);
    for (int i = 0; i < 12; i++) chk("rr_order", log_q[base+i], exp3[i]);
    chk("rr_cnt0", bus.cnt0, 6);
    chk("rr_cnt1", bus.cnt1, 6);

    // pause mid-burst
    tick();
    base = log_q.size();
    for (int i = 1; i <= 8; i++) q0.push_back(10'h030 + 10'(i));
    wait_pop0(20);
    chk("pz_started", bus.pop0, 1);
    tick();
    tick();
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("pz_words_in_pause", log_q.size() - base, 2);
    bus.pause = 1'b0;
    chk("pz_pops", pause_pops, 0);
    chk("pz_valids", pause_valids, 2);
    wait_words(base + 8, 60);
    for (int i = 0; i < 10; i++) settle();
    chk("pz_count", log_q.size() - base, 8);
    for (int i = 0; i < 8; i++) chk("pz_order", log_q[base+i], 10'h031 + 10'(i));
    chk("pz_cnt0", bus.cnt0, 14);

    // class-bit mismatch from FIFO 0
    tick();
    q0.push_back(10'h205);
    wait_pop0(20);
    chk("err_pop", bus.pop0, 1);
    chk("err_pre0", bus.class_err, 0);
    settle();
    chk("err_pre1", bus.class_err, 0);
    settle();
    chk("err_set", bus.class_err, 1);
    chk("err_valid", bus.valid_out, 1);
    chk("err_data", bus.data_out, 10'h205);
    chk("err_cnt0", bus.cnt0, 15);
    tick();
    q1.push_back(10'h211);
    for (int i = 0; i < 10; i++) settle();
    chk("err_sticky", bus.class_err, 1);
    chk("err_cnt1", bus.cnt1, 7);

    // 256 class-1 words wrap cnt1
    do_reset();
    settle();
    chk("wr_rst_err", bus.class_err, 0);
    chk("wr_rst_cnt1", bus.cnt1, 0);
    tick();
    base = log_q.size();
    for (int i = 0; i < 256; i++) q1.push_back(10'h200 | 10'(i & 255));
    wait_words(base + 256, 700);
    for (int i = 0; i < 3; i++) settle();
    chk("wr_count", log_q.size() - base, 256);
    chk("wr_last", log_q[base+255], 10'h2FF);
    chk("wr_cnt1", bus.cnt1, 0);
    chk("wr_cnt0", bus.cnt0, 0);

    // reset mid-stream
    tick();
    base = log_q.size();
    for (int i = 0; i < 10; i++) q1.push_back(10'h2A0 + 10'(i));
    for (int i = 0; i < 30 && !bus.valid_out; i++) settle();
    chk("mr_running", bus.valid_out, 1);
    chk("mr_cnt1_mid", bus.cnt1, 32'((log_q.size() - base) & 255));
    tick();
    #2;
    reset = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("mr_valid", bus.valid_out, 0);
    chk("mr_data", bus.data_out, 0);
    chk("mr_cnt1", bus.cnt1, 0);
    chk("mr_pop1", bus.pop1, 0);
    tick();
    tick();
    reset = 1'b1;
    base = log_q.size();
    for (int i = 0; i < 10; i++) settle();
    chk("mr_no_valid", log_q.size() - base, 0);

    chk("pop_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
